router_input_buffer: RTL
========================

Name: router_input_buffer

Overview:
- Per-port ingress stage of the AXI-Stream NoC router. It sits directly upstream of the dual-channel routing algorithm stage.
- Buffers incoming flits in a FIFO. When a routing-header flit reaches the FIFO head, it decodes target_x/target_y from that flit's TDATA.
- Holds the decoded target stable for the whole packet, so the routing stage sees a constant destination from header acceptance through the TLAST handshake.
- Also tracks a per-port virtual-channel bit (current_grant) that alternates packet by packet.

Parameters:
- DATA_WIDTH, 32, TDATA width.
- ID_WIDTH, 4, TID width. A flit with TID == ROUTING_HEADER (from defines.svh) is a header flit.
- DEPTH, 8, FIFO depth in flits. Must be a power of two, at least 2.
- MAX_ROUTERS_X, 4, mesh X size.
- MAX_ROUTERS_X_WIDTH, $clog2(MAX_ROUTERS_X), width of target_x.
- MAX_ROUTERS_Y, 4, mesh Y size.
- MAX_ROUTERS_Y_WIDTH, $clog2(MAX_ROUTERS_Y), width of target_y.
- X_LSB, 0, bit offset of the X field in the header TDATA.
- Y_LSB, 8, bit offset of the Y field in the header TDATA.
- CHANNEL_NUMBER_WIDTH, 4, width of current_grant.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- s_tvalid  input  1  upstream flit valid
- s_tready  output  1  upstream ready; equals FIFO not full
- s_tdata  input  DATA_WIDTH  upstream data
- s_tlast  input  1  last flit of packet
- s_tid  input  ID_WIDTH  flit type; ROUTING_HEADER marks a header
- m_tvalid  output  1  flit valid toward the routing stage
- m_tready  input  1  routing stage ready
- m_tdata  output  DATA_WIDTH  FIFO head data
- m_tlast  output  1  FIFO head TLAST
- m_tid  output  ID_WIDTH  FIFO head TID
- target_x  output  MAX_ROUTERS_X_WIDTH  latched destination X
- target_y  output  MAX_ROUTERS_Y_WIDTH  latched destination Y
- current_grant  output  CHANNEL_NUMBER_WIDTH  virtual-channel select; only bit 0 toggles, upper bits are 0
- route_valid  output  1  target_x/target_y are valid for the current packet
- occupancy  output  $clog2(DEPTH)+1  number of flits in the FIFO

Behaviour:
- Reset: asynchronous on rst high. All of the following reset to 0: FIFO pointers, occupancy, m_tvalid, route_valid, target_x, target_y, current_grant.
  - s_tready is 1 the first cycle after rst deasserts.
  - FSM resets to IDLE.
  - Reset mid-packet discards all buffered flits; no partial packet is re-emitted.
- FIFO:
  - Write when s_tvalid && s_tready. Read when m_tvalid && m_tready.
  - Simultaneous read and write when full: write is refused (s_tready=0), read proceeds.
  - Simultaneous read and write when non-empty and not full: occupancy is unchanged.
  - Pointers wrap modulo DEPTH; an extra MSB distinguishes full from empty.
  - Latency: a flit written in cycle N is at the head in cycle N+1 (registered storage, no bypass). Minimum in-to-out latency is 1 cycle plus the FSM bubble below.
- FSM, three states:
  - IDLE:
    - m_tvalid=0.
    - Head present with TID==ROUTING_HEADER: load target_x=head_tdata[X_LSB +: MAX_ROUTERS_X_WIDTH] and target_y=head_tdata[Y_LSB +: MAX_ROUTERS_Y_WIDTH]; set route_valid=1; go to HEADER. This is a 1-cycle bubble, so the header is never presented before its target is stable.
    - Head present with TID!=ROUTING_HEADER (orphan body flit): drop it by popping internally, without asserting m_tvalid; stay in IDLE.
  - HEADER:
    - m_tvalid=1 with the header flit at the head.
    - On handshake: if head TLAST=1 (single-flit packet), go to IDLE, clear route_valid, toggle current_grant[0]. Otherwise go to BODY.
  - BODY:
    - m_tvalid = FIFO non-empty.
    - target_x, target_y and current_grant are held constant.
    - On a handshake with TLAST=1: go to IDLE, clear route_valid, toggle current_grant[0].
    - A header TID arriving in BODY is forwarded as data; it does not re-latch the target.
- Stability: target_x, target_y and current_grant change only in IDLE, never while m_tvalid=1.
- m_tvalid, once asserted, stays high until its handshake (AXIS rule). Data is stable while stalled.
- occupancy reflects the registered pointer state; it updates the cycle after push/pop.

Test Plan:
- Reset, then push header TID=ROUTING_HEADER with TDATA=0x0000_0302 and TLAST=0, two body flits, and a TLAST flit, with m_tready=1 -> route_valid rises 1 cycle after the header reaches the head; target_x=2, target_y=3; 4 flits emitted in order; current_grant goes 0→1 after TLAST.
- Push 8 flits with m_tready=0 -> s_tready=0 after the 8th and occupancy=8. Raise m_tready while s_tvalid stays high -> one pop per cycle; writes resume the cycle after the first pop; no flit lost.
- Two back-to-back single-flit packets, (1,1) then (3,0) -> each emitted with a 1-cycle bubble; target changes only between packets; current_grant toggles 0→1→0.
- Body flit with no preceding header -> dropped, m_tvalid never asserted, occupancy returns to 0.
- Assert rst mid-BODY with 3 flits buffered -> next cycle: occupancy=0, m_tvalid=0, route_valid=0, current_grant=0.
- Random m_tready stalls across a 5-flit packet -> target_x, target_y and m_tdata stay stable while m_tvalid=1 && m_tready=0.

Source files
------------

// File: rtl/router_input_buffer.sv
// Per-port ingress buffer for the AXI-Stream NoC router.
// Flits are queued in a small FIFO. A routing header at the FIFO head has its
// destination decoded and latched before the header is offered downstream, so
// the routing stage sees a constant target for the whole packet. A one-bit
// virtual-channel grant alternates on every completed packet.
module router_input_buffer #(
  parameter int DATA_WIDTH           = 32,
  parameter int ID_WIDTH             = 4,
  parameter int DEPTH                = 8,
  parameter int MAX_ROUTERS_X        = 4,
  parameter int MAX_ROUTERS_X_WIDTH  = $clog2(MAX_ROUTERS_X),
  parameter int MAX_ROUTERS_Y        = 4,
  parameter int MAX_ROUTERS_Y_WIDTH  = $clog2(MAX_ROUTERS_Y),
  parameter int X_LSB                = 0,
  parameter int Y_LSB                = 8,
  parameter int CHANNEL_NUMBER_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic [DATA_WIDTH-1:0]           s_tdata,
  input  logic                            s_tlast,
  input  logic [ID_WIDTH-1:0]             s_tid,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tlast,
  output logic [ID_WIDTH-1:0]             m_tid,
  output logic [MAX_ROUTERS_X_WIDTH-1:0]  target_x,
  output logic [MAX_ROUTERS_Y_WIDTH-1:0]  target_y,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] current_grant,
  output logic                            route_valid,
  output logic [$clog2(DEPTH):0]          occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = ID_WIDTH + 1 + DATA_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_BODY   = 2'd2;

  logic [EW-1:0] mem [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        full, empty;
  logic        push, pop, hs, drop;

  logic [EW-1:0]           head;
  logic [ID_WIDTH-1:0]     head_tid;
  logic                    head_tlast;
  logic [DATA_WIDTH-1:0]   head_tdata;
  logic                    head_is_hdr;

  logic [1:0]                     state_q, state_d;
  logic [MAX_ROUTERS_X_WIDTH-1:0] tx_q, tx_d;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] ty_q, ty_d;
  logic                           route_valid_q, route_valid_d;
  logic                           grant_q, grant_d;

  // FIFO bookkeeping; the extra pointer MSB separates full from empty.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign head        = mem[rd_ptr_q[AW-1:0]];
  assign head_tid    = head[EW-1 -: ID_WIDTH];
  assign head_tlast  = head[DATA_WIDTH];
  assign head_tdata  = head[DATA_WIDTH-1:0];
  assign head_is_hdr = (head_tid == ROUTING_HEADER);

  assign s_tready      = ~full;
  assign occupancy     = count;
  assign m_tdata       = head_tdata;
  assign m_tlast       = head_tlast;
  assign m_tid         = head_tid;
  assign target_x      = tx_q;
  assign target_y      = ty_q;
  assign route_valid   = route_valid_q;
  assign current_grant = {{(CHANNEL_NUMBER_WIDTH-1){1'b0}}, grant_q};

  // Downstream valid: never in IDLE (header waits one cycle for its target).
  always_comb begin
    m_tvalid = 1'b0;
    case (state_q)
      ST_HEADER: m_tvalid = 1'b1;
      ST_BODY:   m_tvalid = ~empty;
      default:   m_tvalid = 1'b0;
    endcase
  end

  // Push/pop decisions; orphan body flits are discarded silently from IDLE.
  always_comb begin
    push     = s_tvalid & ~full;
    hs       = m_tvalid & m_tready;
    drop     = (state_q == ST_IDLE) & ~empty & ~head_is_hdr;
    pop      = hs | drop;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  // Packet FSM: latch target in IDLE, hold it until the TLAST handshake.
  always_comb begin
    state_d       = state_q;
    tx_d          = tx_q;
    ty_d          = ty_q;
    route_valid_d = route_valid_q;
    grant_d       = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty && head_is_hdr) begin
          tx_d          = head_tdata[X_LSB +: MAX_ROUTERS_X_WIDTH];
          ty_d          = head_tdata[Y_LSB +: MAX_ROUTERS_Y_WIDTH];
          route_valid_d = 1'b1;
          state_d       = ST_HEADER;
        end
      end
      ST_HEADER, ST_BODY: begin
        if (hs) begin
          if (head_tlast) begin
            state_d       = ST_IDLE;
            route_valid_d = 1'b0;
            grant_d       = ~grant_q;
          end else begin
            state_d = ST_BODY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state with asynchronous reset; buffered flits are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      state_q       <= ST_IDLE;
      tx_q          <= '0;
      ty_q          <= '0;
      route_valid_q <= 1'b0;
      grant_q       <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      state_q       <= state_d;
      tx_q          <= tx_d;
      ty_q          <= ty_d;
      route_valid_q <= route_valid_d;
      grant_q       <= grant_d;
    end
  end

  // Flit storage, written without reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= {s_tid, s_tlast, s_tdata};
    end
  end

endmodule
